// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: spawns moles, scores hits, runs the countdown.
// Optional: define MOLE_SPEEDUP_EN to shorten the mole window as score grows.
module mole_scheduler #(
  parameter int          NUM_HOLES      = 8,
  parameter int          TICKS_PER_MOLE = 4,
  parameter int          GAME_TICKS     = 80,
  parameter int          SCORE_W        = 8,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit_btn,
  output logic [NUM_HOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           time_left,
  output logic [1:0]           state,
  output logic                 game_over,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  localparam int IW = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    UP    = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [7:0]           time_q, time_d;
  logic [7:0]           window_q, window_d;
  logic [IW-1:0]        prev_q, prev_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic                 over_q, over_d;
  logic                 hitp_q, hitp_d;
  logic                 missp_q, missp_d;

  logic [IW-1:0]        raw_idx, spawn_idx;
  logic [NUM_HOLES-1:0] spawn_mole;
  logic [7:0]           win_load;
  logic [SCORE_W-1:0]   score_inc;
  logic                 hit, wrong, game_end, win_end;

`ifdef MOLE_SPEEDUP_EN
  logic [SCORE_W-1:0]   lvl;
  always_comb begin
    lvl = score_q >> 3;
    if (int'(lvl) >= TICKS_PER_MOLE) win_load = 8'd1;
    else win_load = 8'(TICKS_PER_MOLE - int'(lvl));
  end
`else
  assign win_load = 8'(TICKS_PER_MOLE);
`endif

  // Never light the same hole twice in a row.
  always_comb begin
    raw_idx = IW'(lfsr_q % 8'(NUM_HOLES));
    spawn_idx = raw_idx;
    if (raw_idx == prev_q) begin
      if (raw_idx == IW'(NUM_HOLES - 1)) spawn_idx = '0;
      else spawn_idx = raw_idx + IW'(1);
    end
    spawn_mole = '0;
    spawn_mole[spawn_idx] = 1'b1;
  end

  assign hit       = |(hit_btn & mole_q);
  assign wrong     = |(hit_btn & ~mole_q);
  assign game_end  = tick && (time_q == 8'd1);
  assign win_end   = tick && (window_q == 8'd1);
  assign score_inc = (&score_q) ? score_q : score_q + SCORE_W'(1);

  always_comb begin
    state_d  = state_q;
    mole_d   = mole_q;
    score_d  = score_q;
    time_d   = time_q;
    window_d = window_q;
    prev_d   = prev_q;
    hitp_d   = 1'b0;
    missp_d  = 1'b0;
    lfsr_d   = {lfsr_q[6:0],
                lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    unique case (state_q)
      IDLE, DONE: begin
        mole_d = '0;
        if (start) begin
          score_d = '0;
          time_d  = 8'(GAME_TICKS);
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        prev_d = spawn_idx;
        if (tick) time_d = time_q - 8'd1;
        if (game_end) begin
          mole_d  = '0;
          state_d = DONE;
        end else begin
          mole_d   = spawn_mole;
          window_d = win_load;
          state_d  = UP;
        end
      end
      UP: begin
        if (tick) begin
          time_d = time_q - 8'd1;
          if (window_q != 8'd0) window_d = window_q - 8'd1;
        end
        if (hit) begin
          score_d = score_inc;
          hitp_d  = 1'b1;
          mole_d  = '0;
          state_d = game_end ? DONE : SPAWN;
        end else if (game_end) begin
          missp_d = wrong;
          mole_d  = '0;
          state_d = DONE;
        end else begin
          missp_d = wrong;
          if (win_end) begin
            missp_d = 1'b1;
            mole_d  = '0;
            state_d = SPAWN;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    over_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mole_q   <= '0;
      score_q  <= '0;
      time_q   <= '0;
      window_q <= '0;
      prev_q   <= '0;
      lfsr_q   <= LFSR_SEED;
      over_q   <= 1'b0;
      hitp_q   <= 1'b0;
      missp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mole_q   <= mole_d;
      score_q  <= score_d;
      time_q   <= time_d;
      window_q <= window_d;
      prev_q   <= prev_d;
      lfsr_q   <= lfsr_d;
      over_q   <= over_d;
      hitp_q   <= hitp_d;
      missp_q  <= missp_d;
    end
  end

  assign mole       = mole_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign state      = state_q;
  assign game_over  = over_q;
  assign hit_pulse  = hitp_q;
  assign miss_pulse = missp_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler.
// Directed scenarios plus randomized play against a game-rule model.
module tb_mole_scheduler;

  localparam int NH  = 8;
  localparam int TPM = 4;
  localparam int GT  = 10;
  localparam int SW  = 8;

  logic          clk = 1'b0;
  logic          reset, tick, start;
  logic [NH-1:0] hit_btn, mole;
  logic [SW-1:0] score;
  logic [7:0]    time_left;
  logic [1:0]    state;
  logic          game_over, hit_pulse, miss_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mole_scheduler #(
    .NUM_HOLES(NH), .TICKS_PER_MOLE(TPM), .GAME_TICKS(GT),
    .SCORE_W(SW), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .hit_btn(hit_btn), .mole(mole), .score(score),
    .time_left(time_left), .state(state), .game_over(game_over),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  function automatic int win(input int s);
`ifdef MOLE_SPEEDUP_EN
    int v;
    v = TPM - (s >> 3);
    return (v < 1) ? 1 : v;
`else
    return TPM;
`endif
  endfunction

  function automatic int idx_of(input logic [NH-1:0] m);
    for (int i = 0; i < NH; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic cyc(input bit t, input bit s, input logic [NH-1:0] b);
    tick = t; start = s; hit_btn = b;
    @(posedge clk); #1;
    tick = 1'b0; start = 1'b0; hit_btn = '0;
  endtask

  task automatic do_reset();
    tick = 0; start = 0; hit_btn = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 0; start = 0; hit_btn = '0;
    #3;
    checks++;
    if ({state, mole, score, time_left, game_over, hit_pulse, miss_pulse} !== '0) begin
      failures++;
      $display("FAIL reset_async st=%0d mole=%h sc=%0d t=%0d exp all zero",
               state, mole, score, time_left);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cyc(i % 20 == 0, 0, '0);
      checks++;
      if ({state, mole, score, time_left, game_over, hit_pulse, miss_pulse} !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d st=%0d mole=%h sc=%0d hp=%b mp=%b exp zero",
                 i, state, mole, score, hit_pulse, miss_pulse);
      end
    end
  endtask

  task automatic test_hits();
    int prev, hits;
    do_reset();
    cyc(0, 1, '0);
    checks++;
    if (state !== 2'd1 || score !== '0 || time_left !== 8'(GT)) begin
      failures++;
      $display("FAIL start_spawn st=%0d sc=%0d t=%0d exp st=1 sc=0 t=%0d",
               state, score, time_left, GT);
    end
    cyc(0, 0, '0);
    checks++;
    if (!$onehot(mole) || idx_of(mole) == 0 || state !== 2'd2) begin
      failures++;
      $display("FAIL first_mole mole=%h st=%0d exp onehot not hole0 st=2", mole, state);
    end
    prev = idx_of(mole);
    hits = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, '0);
      cyc(0, 0, mole);
      hits += int'(hit_pulse);
      checks++;
      if (mole !== '0 || score !== 8'(k + 1) || miss_pulse !== 1'b0) begin
        failures++;
        $display("FAIL hit_score k=%0d mole=%h sc=%0d mp=%b exp mole=0 sc=%0d mp=0",
                 k, mole, score, miss_pulse, k + 1);
      end
      cyc(0, 0, '0);
      checks++;
      if (!$onehot(mole) || idx_of(mole) == prev) begin
        failures++;
        $display("FAIL no_repeat k=%0d mole=%h prev=%0d exp new onehot hole", k, mole, prev);
      end
      prev = idx_of(mole);
    end
    checks++;
    if (hits != 5 || time_left !== 8'(GT - 5)) begin
      failures++;
      $display("FAIL hit_count got=%0d t=%0d exp 5 t=%0d", hits, time_left, GT - 5);
    end
  endtask

  task automatic test_expiry();
    logic [NH-1:0] m;
    do_reset();
    cyc(0, 1, '0);
    cyc(0, 0, '0);
    for (int r = 0; r < 2; r++) begin
      m = mole;
      for (int j = 1; j <= win(0); j++) begin
        cyc(1, 0, '0);
        checks++;
        if (j < win(0)) begin
          if (mole !== m || miss_pulse !== 1'b0) begin
            failures++;
            $display("FAIL exp_hold r=%0d j=%0d mole=%h mp=%b exp mole=%h mp=0",
                     r, j, mole, miss_pulse, m);
          end
        end else if (mole !== '0 || miss_pulse !== 1'b1 || state !== 2'd1) begin
          failures++;
          $display("FAIL exp_drop r=%0d mole=%h mp=%b st=%0d exp 0 1 1",
                   r, mole, miss_pulse, state);
        end
      end
      cyc(0, 0, '0);
      checks++;
      if (!$onehot(mole) || mole === m) begin
        failures++;
        $display("FAIL exp_respawn r=%0d mole=%h old=%h", r, mole, m);
      end
    end
    checks++;
    if (score !== '0 || time_left !== 8'(GT - 2 * win(0))) begin
      failures++;
      $display("FAIL exp_totals sc=%0d t=%0d exp 0 %0d", score, time_left, GT - 2 * win(0));
    end
  endtask

  task automatic test_wrong();
    logic [NH-1:0] m, bw;
    int h;
    do_reset();
    cyc(0, 1, '0);
    cyc(0, 0, '0);
    m = mole;
    h = idx_of(m);
    bw = '0;
    bw[(h + 3) % NH] = 1'b1;
    cyc(0, 0, bw);
    checks++;
    if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || mole !== m || score !== '0) begin
      failures++;
      $display("FAIL wrong_btn mp=%b hp=%b mole=%h sc=%0d exp 1 0 %h 0",
               miss_pulse, hit_pulse, mole, score, m);
    end
    cyc(0, 0, bw | m);
    checks++;
    if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd1 || mole !== '0) begin
      failures++;
      $display("FAIL both_btn hp=%b mp=%b sc=%0d mole=%h exp 1 0 1 0",
               hit_pulse, miss_pulse, score, mole);
    end
  endtask

  task automatic test_game_end();
    do_reset();
    cyc(0, 1, '0);
    cyc(0, 0, '0);
    for (int i = 0; i < GT - 1; i++) begin
      cyc(1, 0, '0);
      if (mole == '0) cyc(0, 0, '0);
    end
    checks++;
    if (time_left !== 8'd1 || state !== 2'd2) begin
      failures++;
      $display("FAIL end_pre t=%0d st=%0d exp 1 2", time_left, state);
    end
    cyc(1, 0, mole);
    checks++;
    if (score !== 8'd1 || state !== 2'd3 || game_over !== 1'b1 || mole !== '0 ||
        miss_pulse !== 1'b0 || hit_pulse !== 1'b1 || time_left !== 8'd0) begin
      failures++;
      $display("FAIL end_hit sc=%0d st=%0d go=%b mole=%h mp=%b hp=%b t=%0d exp 1 3 1 0 0 1 0",
               score, state, game_over, mole, miss_pulse, hit_pulse, time_left);
    end
    cyc(1, 0, '1);
    cyc(1, 0, 8'h0F);
    checks++;
    if (score !== 8'd1 || state !== 2'd3 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      failures++;
      $display("FAIL done_hold sc=%0d st=%0d hp=%b mp=%b exp 1 3 0 0",
               score, state, hit_pulse, miss_pulse);
    end
    cyc(0, 1, '0);
    checks++;
    if (score !== '0 || time_left !== 8'(GT) || state !== 2'd1 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL restart sc=%0d t=%0d st=%0d go=%b exp 0 %0d 1 0",
               score, time_left, state, game_over, GT);
    end
    // Tick in both spawn cycles so expiry and game end land on one edge.
    cyc(1, 0, '0);
    for (int i = 0; i < TPM; i++) cyc(1, 0, '0);
    cyc(1, 0, '0);
    for (int i = 0; i < TPM - 1; i++) begin
      cyc(1, 0, '0);
      checks++;
      if (miss_pulse !== 1'b0 || mole == '0) begin
        failures++;
        $display("FAIL coinc_pre i=%0d mp=%b mole=%h", i, miss_pulse, mole);
      end
    end
    cyc(1, 0, '0);
    checks++;
    if (state !== 2'd3 || miss_pulse !== 1'b0 || mole !== '0 || game_over !== 1'b1) begin
      failures++;
      $display("FAIL coinc_end st=%0d mp=%b mole=%h go=%b exp 3 0 0 1",
               state, miss_pulse, mole, game_over);
    end
  endtask

  task automatic hit_to(input int target);
    int guard;
    guard = 0;
    while (int'(score) < target && guard < 300) begin
      cyc(0, 0, mole);
      cyc(0, 0, '0);
      guard++;
    end
  endtask

  task automatic test_speedup();
    int targets[2] = '{8, 24};
    int n;
    do_reset();
    cyc(0, 1, '0);
    cyc(0, 0, '0);
    foreach (targets[t]) begin
      hit_to(targets[t]);
      n = 0;
      for (int i = 1; i <= 8; i++) begin
        cyc(1, 0, '0);
        if (mole == '0) begin
          n = i;
          break;
        end
      end
      checks++;
      if (int'(score) != targets[t] || n != win(targets[t]) || miss_pulse !== 1'b1) begin
        failures++;
        $display("FAIL speedup sc=%0d up_ticks=%0d mp=%b exp sc=%0d ticks=%0d mp=1",
                 score, n, miss_pulse, targets[t], win(targets[t]));
      end
      cyc(0, 0, '0);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    cyc(0, 1, '0);
    cyc(0, 0, '0);
    for (int k = 0; k < 259; k++) begin
      cyc(0, 0, mole);
      cyc(0, 0, '0);
    end
    cyc(0, 0, mole);
    checks++;
    if (score !== 8'hFF || hit_pulse !== 1'b1) begin
      failures++;
      $display("FAIL saturate sc=%0d hp=%b exp 255 1", score, hit_pulse);
    end
  endtask

  task automatic test_random();
    int es, et, ew, h, r, nh;
    bit over, t;
    logic [NH-1:0] b, wm, em;
    logic [1:0] est;
    bit ehp, emp;
    do_reset();
    cyc(0, 1, '0);
    cyc(0, 0, '0);
    es = 0; et = GT; ew = win(0); h = idx_of(mole); over = 0;
    for (int it = 0; it < 400; it++) begin
      if (over) begin
        cyc(0, 1, NH'($urandom));
        checks++;
        if (state !== 2'd1 || score !== '0 || time_left !== 8'(GT) || mole !== '0) begin
          failures++;
          $display("FAIL rand_restart it=%0d st=%0d sc=%0d t=%0d", it, state, score, time_left);
        end
        es = 0; et = GT; over = 0;
        cyc(0, 0, '0);
        nh = idx_of(mole);
        checks++;
        if (!$onehot(mole) || nh == h || state !== 2'd2) begin
          failures++;
          $display("FAIL rand_spawn it=%0d mole=%h old=%0d", it, mole, h);
        end
        h = nh; ew = win(es);
        continue;
      end
      wm = NH'($urandom);
      wm[h] = 1'b0;
      if (wm == '0) wm[(h + 1) % NH] = 1'b1;
      r = $urandom_range(0, 9);
      em = '0; em[h] = 1'b1;
      est = 2'd2; ehp = 0; emp = 0;
      if (r <= 3) begin
        t = 1;
        b = ($urandom_range(0, 2) == 0 && et > 1) ? wm : '0;
        et--; ew--;
        if (et == 0) begin
          em = '0; est = 2'd3; over = 1;
        end else if (ew == 0) begin
          em = '0; est = 2'd1; emp = 1;
        end else emp = (b != '0);
      end else if (r <= 5) begin
        t = 0; b = wm; emp = 1;
      end else begin
        t = ($urandom_range(0, 2) == 0);
        b = em | (($urandom_range(0, 1) == 1) ? wm : '0);
        es = (es < 255) ? es + 1 : es;
        if (t) et--;
        em = '0; ehp = 1;
        if (et == 0) begin
          est = 2'd3; over = 1;
        end else est = 2'd1;
      end
      cyc(t, 0, b);
      checks++;
      if ({mole, score, time_left, state, hit_pulse, miss_pulse} !==
          {em, 8'(es), 8'(et), est, ehp, emp}) begin
        failures++;
        $display("FAIL rand_step it=%0d got mole=%h sc=%0d t=%0d st=%0d hp=%b mp=%b exp mole=%h sc=%0d t=%0d st=%0d hp=%b mp=%b",
                 it, mole, score, time_left, state, hit_pulse, miss_pulse,
                 em, es, et, est, ehp, emp);
      end
      if (est == 2'd1) begin
        cyc(0, 0, '0);
        nh = idx_of(mole);
        checks++;
        if (!$onehot(mole) || nh == h || state !== 2'd2) begin
          failures++;
          $display("FAIL rand_respawn it=%0d mole=%h old=%0d st=%0d", it, mole, h, state);
        end
        h = (nh < 0) ? h : nh;
        ew = win(es);
      end
    end
  endtask

  initial begin
    reset = 1'b1; tick = 0; start = 0; hit_btn = '0;
    test_reset();
    test_hits();
    test_expiry();
    test_wrong();
    test_game_end();
    test_speedup();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
